// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for write-back source select and load type,
// common to the decoder, MEM stage and WB stage.
package mem_wb_stage_pkg;

   localparam logic [1:0] WDSEL_ALU = 2'd0;
   localparam logic [1:0] WDSEL_MEM = 2'd1;
   localparam logic [1:0] WDSEL_PC4 = 2'd2;

   localparam logic [2:0] DM_LW  = 3'd0;
   localparam logic [2:0] DM_LH  = 3'd1;
   localparam logic [2:0] DM_LB  = 3'd2;
   localparam logic [2:0] DM_LHU = 3'd3;
   localparam logic [2:0] DM_LBU = 3'd4;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load byte/halfword extraction with sign/zero extension from an aligned word.
// Unknown load types return the whole word.
module load_extend
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0]  dmtype,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] data32
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   always_comb begin
      w_half = off[1] ? word[31:16] : word[15:0];
      w_byte = word[7:0];
      unique case (off)
         2'd0: w_byte = word[7:0];
         2'd1: w_byte = word[15:8];
         2'd2: w_byte = word[23:16];
         2'd3: w_byte = word[31:24];
         default: w_byte = word[7:0];
      endcase
   end

   always_comb begin
      data32 = word;
      case (dmtype)
         DM_LH:   data32 = {{16{w_half[15]}}, w_half};
         DM_LHU:  data32 = {16'h0000, w_half};
         DM_LB:   data32 = {{24{w_byte[7]}}, w_byte};
         DM_LBU:  data32 = {24'h000000, w_byte};
         default: data32 = word;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back mux, register-file write port,
// WB bypass outputs and retired-instruction counter.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic                 flush,
   input  logic                 mem_valid,
   input  logic                 mem_regwrite,
   input  logic [4:0]           mem_rd,
   input  logic [1:0]           mem_wdsel,
   input  logic [2:0]           mem_dmtype,
   input  logic [31:0]          mem_alu_out,
   input  logic [31:0]          mem_rdata,
   input  logic [31:0]          mem_pc,
   output logic                 rf_wr,
   output logic [4:0]           rf_a3,
   output logic [31:0]          rf_wd,
   output logic                 fwd_valid,
   output logic [4:0]           fwd_rd,
   output logic [31:0]          fwd_data,
   output logic [INSTRET_W-1:0] instret
);

   logic                 r_wb_valid;
   logic                 r_wb_new;
   logic                 r_wb_regwrite;
   logic [4:0]           r_wb_rd;
   logic [1:0]           r_wb_wdsel;
   logic [2:0]           r_wb_dmtype;
   logic [31:0]          r_wb_alu_out;
   logic [31:0]          r_wb_rdata;
   logic [31:0]          r_wb_pc;
   logic [INSTRET_W-1:0] r_instret;

   logic [31:0] w_load;
   logic [31:0] w_wd;
   logic        w_dest_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid    <= 1'b0;
         r_wb_new      <= 1'b0;
         r_wb_regwrite <= 1'b0;
         r_wb_rd       <= 5'd0;
         r_wb_wdsel    <= 2'd0;
         r_wb_dmtype   <= 3'd0;
         r_wb_alu_out  <= 32'd0;
         r_wb_rdata    <= 32'd0;
         r_wb_pc       <= 32'd0;
         r_instret     <= '0;
      end else begin
         // Count the instruction leaving WB this cycle, regardless of flush/hold.
         if (r_wb_valid && r_wb_new) begin
            r_instret <= r_instret + INSTRET_W'(1);
         end
         if (flush) begin
            r_wb_valid <= 1'b0;
            r_wb_new   <= 1'b0;
         end else if (hold) begin
            r_wb_new   <= 1'b0;
         end else begin
            r_wb_valid    <= mem_valid;
            r_wb_new      <= mem_valid;
            r_wb_regwrite <= mem_regwrite;
            r_wb_rd       <= mem_rd;
            r_wb_wdsel    <= mem_wdsel;
            r_wb_dmtype   <= mem_dmtype;
            r_wb_alu_out  <= mem_alu_out;
            r_wb_rdata    <= mem_rdata;
            r_wb_pc       <= mem_pc;
         end
      end
   end

   load_extend u_load_extend (
      .dmtype (r_wb_dmtype),
      .off    (r_wb_alu_out[1:0]),
      .word   (r_wb_rdata),
      .data32 (w_load)
   );

   always_comb begin
      w_wd = r_wb_alu_out;
      case (r_wb_wdsel)
         WDSEL_MEM: w_wd = w_load;
         WDSEL_PC4: w_wd = r_wb_pc + 32'd4;
         default:   w_wd = r_wb_alu_out;
      endcase
   end

   assign w_dest_ok = r_wb_valid & r_wb_regwrite & (r_wb_rd != 5'd0);

   // Bypass stays valid across hold; the write itself fires only once.
   assign fwd_valid = w_dest_ok;
   assign fwd_rd    = r_wb_rd;
   assign fwd_data  = w_wd;
   assign rf_wr     = w_dest_ok & r_wb_new;
   assign rf_a3     = r_wb_rd;
   assign rf_wd     = w_wd;
   assign instret   = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (64-bit and 4-bit counter instances).
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst, hold, flush;
   logic        mem_valid, mem_regwrite;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_wdsel;
   logic [2:0]  mem_dmtype;
   logic [31:0] mem_alu_out, mem_rdata, mem_pc;

   logic        rf_wr, fwd_valid;
   logic [4:0]  rf_a3, fwd_rd;
   logic [31:0] rf_wd, fwd_data;
   logic [63:0] instret;

   logic        rf_wr4, fwd_valid4;
   logic [4:0]  rf_a34, fwd_rd4;
   logic [31:0] rf_wd4, fwd_data4;
   logic [3:0]  instret4;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference retire model
   logic [63:0] exp_ret = 64'd0;
   logic        pending = 1'b0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .mem_wdsel(mem_wdsel), .mem_dmtype(mem_dmtype), .mem_alu_out(mem_alu_out),
      .mem_rdata(mem_rdata), .mem_pc(mem_pc),
      .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
   );

   mem_wb_stage #(.INSTRET_W(4)) dut4 (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .mem_wdsel(mem_wdsel), .mem_dmtype(mem_dmtype), .mem_alu_out(mem_alu_out),
      .mem_rdata(mem_rdata), .mem_pc(mem_pc),
      .rf_wr(rf_wr4), .rf_a3(rf_a34), .rf_wd(rf_wd4),
      .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4), .instret(instret4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                          input logic [1:0] ws, input logic [2:0] dm,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] pc);
      mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wdsel = ws;
      mem_dmtype = dm; mem_alu_out = alu; mem_rdata = rdata; mem_pc = pc;
   endtask

   task automatic tick();
      if (rst) begin
         exp_ret = 64'd0;
         pending = 1'b0;
      end else begin
         if (pending) exp_ret = exp_ret + 64'd1;
         pending = (flush || hold) ? 1'b0 : mem_valid;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input string tag);
      check(tag, instret, exp_ret);
      check({tag, "_w4"}, {60'd0, instret4}, {60'd0, exp_ret[3:0]});
   endtask

   logic [2:0]  ld_dm  [7] = '{3'd2, 3'd4, 3'd1, 3'd3, 3'd1, 3'd0, 3'd7};
   logic [1:0]  ld_off [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
   logic [31:0] ld_exp [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02,
                               32'h00007F02, 32'h80F17F02, 32'h80F17F02};

   initial begin
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      set_mem(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
      tick();
      tick();
      check("rst_rf_wr", {63'd0, rf_wr}, 64'd0);
      check("rst_rf_a3", {59'd0, rf_a3}, 64'd0);
      check("rst_rf_wd", {32'd0, rf_wd}, 64'd0);
      check("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      check("rst_fwd_rd", {59'd0, fwd_rd}, 64'd0);
      check("rst_fwd_data", {32'd0, fwd_data}, 64'd0);
      check_cnt("rst_instret");

      // ALU write-back
      rst = 1'b0;
      set_mem(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'hDEADBEEF, 32'd0, 32'h100);
      tick();
      check("alu_rf_wr", {63'd0, rf_wr}, 64'd1);
      check("alu_rf_a3", {59'd0, rf_a3}, 64'd5);
      check("alu_rf_wd", {32'd0, rf_wd}, 64'hDEADBEEF);
      check("alu_instret_before", instret, 64'd0);
      mem_valid = 1'b0;
      tick();
      check("alu_instret_after", instret, 64'd1);
      check("alu_bubble_rf_wr", {63'd0, rf_wr}, 64'd0);

      // Load extraction, back-to-back
      for (int i = 0; i < 7; i++) begin
         set_mem(1'b1, 1'b1, 5'd3, 2'd1, ld_dm[i], {30'd0, ld_off[i]}, 32'h80F17F02, 32'h0);
         tick();
         check($sformatf("load%0d_rf_wd", i), {32'd0, rf_wd}, {32'd0, ld_exp[i]});
         check($sformatf("load%0d_fwd_data", i), {32'd0, fwd_data}, {32'd0, ld_exp[i]});
         check_cnt($sformatf("load%0d_instret", i));
      end

      // x0 destination, then PC+4 wrap, then reserved wdsel
      set_mem(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h55, 32'd0, 32'd0);
      tick();
      check("x0_rf_wr", {63'd0, rf_wr}, 64'd0);
      check("x0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      set_mem(1'b1, 1'b1, 5'd9, 2'd2, 3'd0, 32'h77, 32'd0, 32'hFFFFFFFC);
      tick();
      check_cnt("x0_instret");
      check("pc4_rf_wr", {63'd0, rf_wr}, 64'd1);
      check("pc4_rf_wd", {32'd0, rf_wd}, 64'd0);
      set_mem(1'b1, 1'b1, 5'd9, 2'd3, 3'd0, 32'hCAFEF00D, 32'h11111111, 32'h20);
      tick();
      check("wdsel3_rf_wd", {32'd0, rf_wd}, 64'hCAFEF00D);

      // Hold: write once, bypass stays valid
      set_mem(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h1234, 32'd0, 32'd0);
      tick();
      check("hold0_rf_wr", {63'd0, rf_wr}, 64'd1);
      check("hold0_fwd_valid", {63'd0, fwd_valid}, 64'd1);
      hold = 1'b1;
      set_mem(1'b1, 1'b1, 5'd8, 2'd0, 3'd0, 32'h9999, 32'd0, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("hold%0d_rf_wr", i), {63'd0, rf_wr}, 64'd0);
         check($sformatf("hold%0d_fwd_valid", i), {63'd0, fwd_valid}, 64'd1);
         check($sformatf("hold%0d_fwd_rd", i), {59'd0, fwd_rd}, 64'd7);
         check($sformatf("hold%0d_fwd_data", i), {32'd0, fwd_data}, 64'h1234);
         check_cnt($sformatf("hold%0d_instret", i));
      end

      // flush beats hold
      flush = 1'b1;
      set_mem(1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 32'hABCD, 32'd0, 32'd0);
      tick();
      check("flush_rf_wr", {63'd0, rf_wr}, 64'd0);
      check("flush_fwd_valid", {63'd0, fwd_valid}, 64'd0);
      flush = 1'b0; hold = 1'b0;
      mem_valid = 1'b0;
      tick();
      check_cnt("flush_instret");

      // Counter wrap on the 4-bit instance
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_cnt("wrap_rst");
      for (int i = 0; i < 17; i++) begin
         set_mem(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, i, 32'd0, 32'd0);
         tick();
      end
      mem_valid = 1'b0;
      tick();
      check("wrap_w4", {60'd0, instret4}, 64'd1);
      check("wrap_w64", instret, 64'd17);

      // Reset mid-stream suppresses the pending write
      set_mem(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 32'h44, 32'd0, 32'd0);
      tick();
      check("mid_pre_rf_wr", {63'd0, rf_wr}, 64'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_rf_wr", {63'd0, rf_wr}, 64'd0);
      check("mid_rst_rf_wr_w4", {63'd0, rf_wr4}, 64'd0);
      check_cnt("mid_rst_instret");
      rst = 1'b0;
      mem_valid = 1'b0;
      tick();
      check("mid_post_rf_wr", {63'd0, rf_wr}, 64'd0);
      check_cnt("mid_post_instret");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
